// File: rtl/timer_ctrl.sv
// Stopwatch/countdown timer controller: drives an external counter chain, pauses,
// and raises a self-clearing alarm when the chain hits its terminal value.
module timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       dir,
  input  logic       zero_in,
  input  logic       max_in,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_clr,
  output logic       alarm,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       terminal;

  // Terminal blocks the step so the chain never wraps past zero or max.
  assign terminal = dir_q ? max_in : zero_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      alarm_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (!clr && !stop && start && (dir || !zero_in)) begin
          state_d = RUN;
          dir_d   = dir;
        end
      end
      RUN: begin
        if (clr)                   state_d = IDLE;
        else if (stop)             state_d = PAUSE;
        else if (tick && terminal) state_d = ALARM;
      end
      PAUSE: begin
        if (clr)                  state_d = IDLE;
        else if (!stop && start)  state_d = RUN;
      end
      ALARM: begin
        if (clr || stop || start)                     state_d = IDLE;
        else if (tick && (alarm_cnt_q == ALARM_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter only lives while staying in ALARM, so every entry starts from zero.
    if ((state_q == ALARM) && (state_d == ALARM))
      alarm_cnt_d = tick ? alarm_cnt_q + 8'd1 : alarm_cnt_q;
    else
      alarm_cnt_d = 8'd0;
  end

  always_comb begin
    state   = state_q;
    cnt_up  = dir_q;
    alarm   = (state_q == ALARM);
    running = (state_q == RUN);
    cnt_clr = clr && !reset;
    cnt_en  = !reset && (state_q == RUN) && tick && !terminal && !stop && !clr;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: stimulus pushes per-cycle expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic       dir = 1'b0, zero_in = 1'b0, max_in = 1'b0;
  logic       cnt_en, cnt_up, cnt_clr, alarm, running;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [6:0] e;
  } exp_t;

  exp_t exp_q[$];

  timer_ctrl #(.ALARM_TICKS(10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .dir(dir), .zero_in(zero_in), .max_in(max_in), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_clr(cnt_clr), .alarm(alarm), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: {cnt_en, cnt_up, cnt_clr, alarm, running, state[1:0]}
  function automatic logic [6:0] ev(logic en, logic up, logic cl, logic al, logic rn, logic [1:0] st);
    return {en, up, cl, al, rn, st};
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t it;
      logic [6:0] got;
      it  = exp_q.pop_front();
      got = {cnt_en, cnt_up, cnt_clr, alarm, running, state};
      checks++;
      if (got !== it.e) begin
        failures++;
        $display("FAIL %s got={en,up,clr,al,run,st}=%b expected=%b", it.nm, got, it.e);
      end
    end
  end

  task automatic push(input string nm, input logic [6:0] e);
    exp_t it;
    it.nm = nm;
    it.e  = e;
    exp_q.push_back(it);
  endtask

  task automatic cyc(input string nm, input logic t, input logic s, input logic p, input logic c,
                     input logic d, input logic z, input logic m, input logic [6:0] e);
    @(posedge clk);
    #1;
    tick = t; start = s; stop = p; clr = c; dir = d; zero_in = z; max_in = m;
    push(nm, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state, with clr and tick active to confirm outputs stay gated
    cyc("reset_state", 1, 0, 0, 1, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    cyc("reset_state2", 1, 1, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    @(posedge clk); #1; reset = 1'b0; tick = 0; start = 0; clr = 0;

    // count up, 5 ticks
    cyc("up_start", 0, 1, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    for (int i = 0; i < 5; i++) begin
      cyc("up_tick", 1, 0, 0, 0, 0, 0, 0, ev(1, 1, 0, 0, 1, 2'b01));
      if (i == 2) cyc("up_notick", 0, 0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 1, 2'b01));
    end
    cyc("up_clr", 0, 0, 0, 1, 0, 0, 0, ev(0, 1, 1, 0, 1, 2'b01));
    cyc("up_idle", 0, 0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));

    // countdown to zero, then alarm for 10 ticks
    cyc("dn_start", 0, 1, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    cyc("dn_tick1", 1, 0, 0, 0, 1, 0, 0, ev(1, 0, 0, 0, 1, 2'b01));
    cyc("dn_tick2", 1, 0, 0, 0, 1, 0, 0, ev(1, 0, 0, 0, 1, 2'b01));
    cyc("dn_zero", 0, 0, 0, 0, 1, 1, 0, ev(0, 0, 0, 0, 1, 2'b01));
    cyc("dn_term_tick", 1, 0, 0, 0, 1, 1, 0, ev(0, 0, 0, 0, 1, 2'b01));
    for (int i = 0; i < 10; i++) begin
      cyc("alarm_tick", 1, 0, 0, 0, 0, 1, 0, ev(0, 0, 0, 1, 0, 2'b11));
      if (i == 3) cyc("alarm_notick", 0, 0, 0, 0, 0, 1, 0, ev(0, 0, 0, 1, 0, 2'b11));
    end
    cyc("alarm_expired", 0, 0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 2'b00));

    // start refused at zero in countdown mode
    cyc("zero_start", 0, 1, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 2'b00));
    cyc("zero_stay1", 1, 0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 2'b00));
    cyc("zero_stay2", 1, 0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 2'b00));

    // pause and resume; dir ignored on resume
    cyc("p_start", 0, 1, 0, 0, 1, 0, 0, ev(0, 0, 0, 0, 0, 2'b00));
    cyc("p_tick", 1, 0, 0, 0, 1, 0, 0, ev(1, 1, 0, 0, 1, 2'b01));
    cyc("p_stop_tick", 1, 0, 1, 0, 1, 0, 0, ev(0, 1, 0, 0, 1, 2'b01));
    cyc("p_resume", 0, 1, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b10));
    cyc("p_run_tick", 1, 0, 0, 0, 0, 0, 0, ev(1, 1, 0, 0, 1, 2'b01));
    // terminal at max, then acknowledge with start
    cyc("max_tick", 1, 0, 0, 0, 0, 0, 1, ev(0, 1, 0, 0, 1, 2'b01));
    cyc("ack_start", 0, 1, 0, 0, 0, 0, 1, ev(0, 1, 0, 1, 0, 2'b11));
    cyc("ack_idle", 0, 0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));

    // clr beats stop and start
    cyc("c_start", 0, 1, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    cyc("c_tick", 1, 0, 0, 0, 1, 0, 0, ev(1, 1, 0, 0, 1, 2'b01));
    cyc("c_all", 1, 1, 1, 1, 1, 0, 0, ev(0, 1, 1, 0, 1, 2'b01));
    cyc("c_idle", 0, 0, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));

    // async reset mid-ALARM
    cyc("r_start", 0, 1, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    cyc("r_term", 1, 0, 0, 0, 1, 0, 1, ev(0, 1, 0, 0, 1, 2'b01));
    for (int i = 0; i < 3; i++)
      cyc("r_alarm_tick", 1, 0, 0, 0, 1, 0, 1, ev(0, 1, 0, 1, 0, 2'b11));
    @(posedge clk);
    #1;
    tick = 1; start = 0; stop = 0; clr = 1; max_in = 1;
    #2;
    reset = 1'b1;
    push("r_async", ev(0, 1, 0, 0, 0, 2'b00));
    cyc("r_hold", 1, 1, 0, 1, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    @(posedge clk); #1; reset = 1'b0; tick = 0; start = 0; clr = 0;
    cyc("r_wait", 1, 0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));

    // fresh alarm lasts exactly 10 ticks
    cyc("f_start", 0, 1, 0, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));
    cyc("f_term", 1, 0, 0, 0, 0, 0, 1, ev(0, 1, 0, 0, 1, 2'b01));
    for (int i = 0; i < 10; i++)
      cyc("f_alarm_tick", 1, 0, 0, 0, 0, 0, 1, ev(0, 1, 0, 1, 0, 2'b11));
    cyc("f_expired", 0, 0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 2'b00));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
